mode_select_register: RTL and testbench
=======================================

Name: mode_select_register

Overview:
- Parameterised parallel-out register; default width 4.
- A 2-bit mode select picks the next-state function every clock: hold, complement, shift right or shift left.
- Each bit is a D flip-flop fed by a 4:1 mux.
- General-purpose datapath/state element; D supplies the serial fill bits for both shift modes.

Parameters:
- WIDTH, 4, register width in bits (minimum 2).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset; clears Y.
- D  input  WIDTH  data input; D[WIDTH-1] is the shift-right fill bit, D[0] is the shift-left fill bit.
- S  input  2  mode select: 00 hold, 01 complement, 10 shift right, 11 shift left.
- Y  output  WIDTH  registered output (current register contents).

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RESET).
- RESET=1: Y <= 0 immediately, independent of CLK; held at 0 while asserted. RESET has priority over all modes.
- Each rising CLK edge with RESET=0, next Y depends on S:
  - S=00 hold: Y unchanged.
  - S=01 complement: Y <= ~Y (bitwise).
  - S=10 shift right: Y <= {D[WIDTH-1], Y[WIDTH-1:1]}; Y[0] is discarded.
  - S=11 shift left: Y <= {Y[WIDTH-2:0], D[0]}; Y[WIDTH-1] is discarded.
- Latency: one cycle from S/D sampling to Y update. Y is purely registered; no combinational path from inputs to Y.
- D, except the two fill bits, is not loaded in the base configuration.
- No X propagation from S: all four codes are defined.
- RESET deassertion: first update at the next rising edge after release.
- RESET asserted mid-sequence: contents lost; Y=0.

Optional Feature:
- Macro: MODE_REG_PARALLEL_LOAD_EN.
- Defined:
  - Adds input LOAD (1 bit).
  - On a rising edge with RESET=0 and LOAD=1: Y <= D, overriding S.
  - LOAD=0: normal S-mode behaviour.
  - RESET still has highest priority.
- Undefined: no LOAD port; behaviour exactly as above.

Decomposition:
- Package mode_select_register_pkg:
  - 2-bit mode type with constants MODE_HOLD=2'b00, MODE_CMPL=2'b01, MODE_SHR=2'b10, MODE_SHL=2'b11.
  - Reset value constant (all zeros).
- One natural sub-module, mode_reg_bit_cell:
  - 4:1 mux over {self, ~self, left-neighbour, right-neighbour} plus an async-reset DFF.
  - Instantiated WIDTH times via generate.
  - End cells receive the fill bits D[WIDTH-1] (MSB, shift right) and D[0] (LSB, shift left).

Test Plan:
- Reset: RESET=1 with arbitrary D/S, no clock edge -> Y=0000 immediately. Release; S=00, D=1101, one edge -> Y=0000.
- Complement: from Y=0000, S=01 -> 1111 after edge 1, 0000 after edge 2. From 1010 -> 0101.
- Shift right: Y=1010, D=0xxx, S=10 -> 0101. Same start with D=1xxx -> 1101.
- Shift left: Y=1010, D=xxx1, S=11 -> 0101. Same start with D=xxx0 -> 0100. Then 1000 after a further edge with D[0]=0.
- Directed sequence: reset, then D=1101 held, one edge each of S=00,01,10,11 -> Y = 0000, 1111, 1111, 1111.
- Async reset: assert RESET mid-cycle with Y=1111 -> Y=0000 before the next edge. With MODE_REG_PARALLEL_LOAD_EN, LOAD=1, D=1101, S=01 -> Y=1101.

Source files
------------

// File: rtl/mode_select_register_pkg.sv
// mode_select_register_pkg
//   Shared types and constants for the mode select register.
//   mode_t    : 2-bit next-state function select (hold/complement/shr/shl)
//   RESET_BIT : value every register bit takes while reset is asserted
package mode_select_register_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_CMPL = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_t;

  localparam logic RESET_BIT = 1'b0;

endpackage : mode_select_register_pkg

// File: rtl/mode_select_register_if.sv
// mode_select_register_if
//   Bus bundle for the mode select register.
//   d    : data input; d[WIDTH-1] = shift-right fill, d[0] = shift-left fill
//   s    : mode select (mode_t)
//   load : parallel load strobe (only with MODE_REG_PARALLEL_LOAD_EN)
//   y    : registered register contents
//   Modports: master drives d/s/load and observes y; slave is the register.
interface mode_select_register_if #(
  parameter int WIDTH = 4
);
  import mode_select_register_pkg::*;

  logic [WIDTH-1:0] d;
  mode_t            s;
  logic [WIDTH-1:0] y;
`ifdef MODE_REG_PARALLEL_LOAD_EN
  logic             load;
`endif

`ifdef MODE_REG_PARALLEL_LOAD_EN
  modport master (output d, output s, output load, input y);
  modport slave  (input d, input s, input load, output y);
`else
  modport master (output d, output s, input y);
  modport slave  (input d, input s, output y);
`endif

endinterface : mode_select_register_if

// File: rtl/mode_reg_bit_cell.sv
// mode_reg_bit_cell
//   One register bit: a 4:1 next-state mux over {self, ~self, shr_src,
//   shl_src} feeding an async-reset D flip-flop.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, forces q to RESET_BIT
//   mode     : next-state select
//   shr_src  : bit taken on shift right (next-higher bit, or the MSB fill)
//   shl_src  : bit taken on shift left (next-lower bit, or the LSB fill)
//   load     : parallel load strobe (MODE_REG_PARALLEL_LOAD_EN only)
//   load_bit : value captured on load (MODE_REG_PARALLEL_LOAD_EN only)
//   q        : registered bit
module mode_reg_bit_cell
  import mode_select_register_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  mode_t mode,
  input  logic  shr_src,
  input  logic  shl_src,
`ifdef MODE_REG_PARALLEL_LOAD_EN
  input  logic  load,
  input  logic  load_bit,
`endif
  output logic  q
);

  function automatic logic next_bit(input mode_t m, input logic self,
                                    input logic r_src, input logic l_src);
    logic nb;
    case (m)
      MODE_HOLD: nb = self;
      MODE_CMPL: nb = ~self;
      MODE_SHR:  nb = r_src;
      default:   nb = l_src;
    endcase
    return nb;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_BIT;
`ifdef MODE_REG_PARALLEL_LOAD_EN
    end else if (load) begin
      q <= load_bit;
`endif
    end else begin
      q <= next_bit(mode, q, shr_src, shl_src);
    end
  end

endmodule : mode_reg_bit_cell

// File: rtl/mode_select_register.sv
// mode_select_register
//   WIDTH-bit parallel-out register whose next state each clock is chosen
//   by a 2-bit mode: hold, complement, shift right, shift left. The data
//   bus only supplies the serial fill bits (d[WIDTH-1] for shift right,
//   d[0] for shift left) unless MODE_REG_PARALLEL_LOAD_EN is defined, in
//   which case load=1 captures all of d, overriding the mode.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears y immediately
//   bus : mode_select_register_if.slave (d, s, [load], y)
module mode_select_register
  import mode_select_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  mode_select_register_if.slave bus
);

  logic [WIDTH-1:0] q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shr_src;
    logic shl_src;

    // End cells take the fill bits; inner cells take their neighbours.
    if (i == WIDTH - 1) begin : g_msb
      assign shr_src = bus.d[WIDTH-1];
    end else begin : g_inner_r
      assign shr_src = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign shl_src = bus.d[0];
    end else begin : g_inner_l
      assign shl_src = q[i-1];
    end

    mode_reg_bit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .mode     (bus.s),
      .shr_src  (shr_src),
      .shl_src  (shl_src),
`ifdef MODE_REG_PARALLEL_LOAD_EN
      .load     (bus.load),
      .load_bit (bus.d[i]),
`endif
      .q        (q[i])
    );
  end

  assign bus.y = q;

endmodule : mode_select_register

// File: tb/tb_mode_select_register.sv
// tb_mode_select_register
//   Self-checking bench: directed cases followed by randomized traffic,
//   compared against an arithmetic reference model of the register.
module tb_mode_select_register;
  import mode_select_register_pkg::*;

  localparam int W = 4;
  localparam logic [W-1:0] MASK = {W{1'b1}};

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] model;

  mode_select_register_if #(.WIDTH(W)) bus ();

  mode_select_register #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next state from the mode rules, using plain shifts/masks.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur,
                                            input logic [1:0] s,
                                            input logic [W-1:0] d,
                                            input logic ld);
    int v;
    int c;
    c = int'(cur);
    if (ld) return d;
    case (s)
      2'd0:    v = c;
      2'd1:    v = c ^ int'(MASK);
      2'd2:    v = (c >> 1) + (d[W-1] ? (1 << (W - 1)) : 0);
      default: v = ((c << 1) & int'(MASK)) + (d[0] ? 1 : 0);
    endcase
    return v[W-1:0];
  endfunction

  // Apply inputs, take one clock edge, update model, check 1 ns later.
  task automatic step(input string tag, input logic [1:0] s,
                      input logic [W-1:0] d, input logic ld);
    bus.s = mode_t'(s);
    bus.d = d;
`ifdef MODE_REG_PARALLEL_LOAD_EN
    bus.load = ld;
`endif
    @(posedge clk);
    #1;
`ifdef MODE_REG_PARALLEL_LOAD_EN
    model = ref_next(model, s, d, ld);
`else
    model = ref_next(model, s, d, 1'b0);
`endif
    check(tag, bus.y, model);
  endtask

  // Build an arbitrary state by shifting it in from the LSB, MSB first.
  task automatic set_state(input logic [W-1:0] v);
    logic [W-1:0] fill;
    for (int i = W - 1; i >= 0; i--) begin
      fill = '0;
      fill[0] = v[i];
      step("set_state", 2'b11, fill, 1'b0);
    end
  endtask

  // Async reset asserted between edges; y must clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model = '0;
    check(tag, bus.y, model);
    @(posedge clk);
    #1;
    check({tag, "_held"}, bus.y, model);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model  = '0;
    bus.d  = 4'($urandom);
    bus.s  = mode_t'($urandom_range(3));
`ifdef MODE_REG_PARALLEL_LOAD_EN
    bus.load = 1'b0;
`endif
    rst = 1'b1;
    #3;
    check("reset_no_clock", bus.y, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("hold_after_reset", 2'b00, 4'b1101, 1'b0);
    check("hold_after_reset_const", bus.y, 4'b0000);

    step("cmpl_1", 2'b01, 4'($urandom), 1'b0);
    check("cmpl_1_const", bus.y, 4'b1111);
    step("cmpl_2", 2'b01, 4'($urandom), 1'b0);
    check("cmpl_2_const", bus.y, 4'b0000);
    set_state(4'b1010);
    check("set_1010", bus.y, 4'b1010);
    step("cmpl_1010", 2'b01, 4'b0000, 1'b0);
    check("cmpl_1010_const", bus.y, 4'b0101);

    set_state(4'b1010);
    step("shr_fill0", 2'b10, 4'b0110, 1'b0);
    check("shr_fill0_const", bus.y, 4'b0101);
    set_state(4'b1010);
    step("shr_fill1", 2'b10, 4'b1001, 1'b0);
    check("shr_fill1_const", bus.y, 4'b1101);

    set_state(4'b1010);
    step("shl_fill1", 2'b11, 4'b0111, 1'b0);
    check("shl_fill1_const", bus.y, 4'b0101);
    set_state(4'b1010);
    step("shl_fill0", 2'b11, 4'b1110, 1'b0);
    check("shl_fill0_const", bus.y, 4'b0100);
    step("shl_fill0_again", 2'b11, 4'b0010, 1'b0);
    check("shl_fill0_again_const", bus.y, 4'b1000);

    // Directed sequence from reset with d held at 1101.
    async_reset("seq_reset");
    step("seq_hold", 2'b00, 4'b1101, 1'b0);
    check("seq_hold_const", bus.y, 4'b0000);
    step("seq_cmpl", 2'b01, 4'b1101, 1'b0);
    check("seq_cmpl_const", bus.y, 4'b1111);
    step("seq_shr", 2'b10, 4'b1101, 1'b0);
    check("seq_shr_const", bus.y, 4'b1111);
    step("seq_shl", 2'b11, 4'b1101, 1'b0);
    check("seq_shl_const", bus.y, 4'b1111);

    async_reset("async_mid");

`ifdef MODE_REG_PARALLEL_LOAD_EN
    step("load_over_cmpl", 2'b01, 4'b1101, 1'b1);
    check("load_over_cmpl_const", bus.y, 4'b1101);
    step("load_off_cmpl", 2'b01, 4'b0000, 1'b0);
    check("load_off_cmpl_const", bus.y, 4'b0010);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(39) == 0) begin
        async_reset("rand_reset");
      end else begin
        step("rand", 2'($urandom_range(3)), 4'($urandom),
             ($urandom_range(7) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mode_select_register
